// File: rtl/round_ctrl.sv
// Game-round sequencer: debounces start/pause keys, drives the countdown timer's
// control bits, and counts expired rounds up to MAX_ROUNDS.
module round_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned CLEAR_CYCLES    = 50_000_001,
  parameter int unsigned MAX_ROUNDS      = 9
) (
  input  logic       clock_50,
  input  logic       resetn,
  input  logic       start_key,
  input  logic       pause_key,
  input  logic       time_out,
  output logic [1:0] timer_ctrl,
  output logic [3:0] round_cnt,
  output logic       running,
  output logic       game_over
);

  localparam int unsigned DbW  = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam int unsigned ClrW = $clog2(CLEAR_CYCLES) + 1;
  localparam logic [DbW-1:0]  DbMax    = DbW'(DEBOUNCE_CYCLES);
  localparam logic [ClrW-1:0] ClrLoad  = ClrW'(CLEAR_CYCLES - 1);
  localparam logic [3:0]      RoundMax = 4'(MAX_ROUNDS);

  typedef enum logic [2:0] {
    StIdle,
    StClear,
    StRun,
    StPaused,
    StExpired
  } state_e;

  // Index 0 is start, index 1 is pause.
  logic [1:0]     key_raw;
  logic [1:0]     key_s1, key_s2, key_s3;
  logic [1:0]     key_stable, key_armed, key_pulse;
  logic [DbW-1:0] db_cnt [2];

  logic           tmo_s1, tmo_s;

  state_e          state_q, state_d;
  logic [ClrW-1:0] clr_cnt_q, clr_cnt_d;
  logic [3:0]      round_q, round_d;

  assign key_raw = {pause_key, start_key};

  // Synchronize both keys, count consecutive equal samples, pulse on an accepted press.
  // key_s3 only serves to detect a change of the synchronized level.
  // key_armed stays low until a released level has been accepted, so a key held
  // through reset never produces a pulse.
  always_ff @(posedge clock_50 or negedge resetn) begin
    if (!resetn) begin
      key_s1     <= '1;
      key_s2     <= '1;
      key_s3     <= '1;
      key_stable <= '1;
      key_armed  <= '0;
      key_pulse  <= '0;
      for (int i = 0; i < 2; i++) begin
        db_cnt[i] <= '0;
      end
    end else begin
      key_s1 <= key_raw;
      key_s2 <= key_s1;
      key_s3 <= key_s2;
      for (int i = 0; i < 2; i++) begin
        key_pulse[i] <= 1'b0;
        if (key_s2[i] != key_s3[i]) begin
          db_cnt[i] <= DbW'(1);
        end else if (db_cnt[i] != DbMax) begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end else begin
          key_stable[i] <= key_s2[i];
          key_pulse[i]  <= key_armed[i] & key_stable[i] & ~key_s2[i];
          if (key_s2[i]) begin
            key_armed[i] <= 1'b1;
          end
        end
      end
    end
  end

  // Two-flop synchronizer for the timer's time_out level.
  always_ff @(posedge clock_50 or negedge resetn) begin
    if (!resetn) begin
      tmo_s1 <= 1'b0;
      tmo_s  <= 1'b0;
    end else begin
      tmo_s1 <= time_out;
      tmo_s  <= tmo_s1;
    end
  end

  // State, clear-hold counter and round counter registers.
  always_ff @(posedge clock_50 or negedge resetn) begin
    if (!resetn) begin
      state_q   <= StIdle;
      clr_cnt_q <= '0;
      round_q   <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      round_q   <= round_d;
    end
  end

  // Next-state logic; priority within a cycle is time_out, then start, then pause.
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    round_d   = round_q;
    case (state_q)
      StIdle: begin
        if (key_pulse[0]) begin
          state_d   = StClear;
          clr_cnt_d = ClrLoad;
        end
      end
      StClear: begin
        if (clr_cnt_q == '0) begin
          state_d = StRun;
        end else begin
          clr_cnt_d = clr_cnt_q - 1'b1;
        end
      end
      StRun: begin
        if (tmo_s) begin
          state_d = StExpired;
          if (round_q != RoundMax) begin
            round_d = round_q + 1'b1;
          end
        end else if (key_pulse[0]) begin
          state_d   = StClear;
          clr_cnt_d = ClrLoad;
        end else if (key_pulse[1]) begin
          state_d = StPaused;
        end
      end
      StPaused: begin
        if (key_pulse[0]) begin
          state_d   = StClear;
          clr_cnt_d = ClrLoad;
        end else if (key_pulse[1]) begin
          state_d = StRun;
        end
      end
      StExpired: begin
        if (key_pulse[0]) begin
          if (round_q == RoundMax) begin
            state_d = StIdle;
            round_d = '0;
          end else begin
            state_d   = StClear;
            clr_cnt_d = ClrLoad;
          end
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Outputs decoded directly from registered state.
  always_comb begin
    timer_ctrl = 2'b11;
    case (state_q)
      StRun:     timer_ctrl = 2'b00;
      StPaused:  timer_ctrl = 2'b10;
      StExpired: timer_ctrl = 2'b10;
      default:   timer_ctrl = 2'b11;
    endcase
    round_cnt = round_q;
    running   = (state_q == StRun);
    game_over = (round_q == RoundMax);
  end

endmodule

// File: tb/tb_round_ctrl.sv
// Self-checking bench for round_ctrl with a mode-level reference model.
module tb_round_ctrl;

  localparam int D  = 4;
  localparam int C  = 8;
  localparam int MR = 2;

  localparam int MIdle    = 0;
  localparam int MClear   = 1;
  localparam int MRun     = 2;
  localparam int MPaused  = 3;
  localparam int MExpired = 4;

  localparam int EvStart = 0;
  localparam int EvPause = 1;
  localparam int EvTmo   = 2;

  logic       clock_50 = 1'b0;
  logic       resetn;
  logic       start_key;
  logic       pause_key;
  logic       time_out;
  logic [1:0] timer_ctrl;
  logic [3:0] round_cnt;
  logic       running;
  logic       game_over;

  int errors = 0;
  int checks = 0;
  int m_mode = MIdle;
  int m_rounds = 0;

  round_ctrl #(
    .DEBOUNCE_CYCLES(D),
    .CLEAR_CYCLES   (C),
    .MAX_ROUNDS     (MR)
  ) dut (
    .clock_50  (clock_50),
    .resetn    (resetn),
    .start_key (start_key),
    .pause_key (pause_key),
    .time_out  (time_out),
    .timer_ctrl(timer_ctrl),
    .round_cnt (round_cnt),
    .running   (running),
    .game_over (game_over)
  );

  always #5 clock_50 = ~clock_50;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic logic [1:0] exp_ctrl(input int mode);
    case (mode)
      MRun:              return 2'b00;
      MPaused, MExpired: return 2'b10;
      default:           return 2'b11;
    endcase
  endfunction

  // Advance n rising edges, then settle 1 ns past the last edge.
  task automatic tick(input int n);
    repeat (n) @(posedge clock_50);
    #1;
  endtask

  task automatic check_all(input string tag);
    logic [1:0] ec;
    logic [3:0] er;
    logic       erun;
    logic       ego;
    ec   = exp_ctrl(m_mode);
    er   = 4'(m_rounds);
    erun = (m_mode == MRun);
    ego  = (m_rounds == MR);
    checks++;
    assert (timer_ctrl === ec) else begin
      errors++;
      $error("FAIL %s timer_ctrl got=%b exp=%b", tag, timer_ctrl, ec);
    end
    checks++;
    assert (round_cnt === er) else begin
      errors++;
      $error("FAIL %s round_cnt got=%0d exp=%0d", tag, round_cnt, er);
    end
    checks++;
    assert (running === erun) else begin
      errors++;
      $error("FAIL %s running got=%b exp=%b", tag, running, erun);
    end
    checks++;
    assert (game_over === ego) else begin
      errors++;
      $error("FAIL %s game_over got=%b exp=%b", tag, game_over, ego);
    end
  endtask

  // Reference behaviour of one accepted event, straight from the round rules.
  task automatic model_event(input int ev);
    case (m_mode)
      MIdle:   if (ev == EvStart) m_mode = MClear;
      MRun: begin
        if (ev == EvTmo) begin
          m_mode = MExpired;
          if (m_rounds < MR) m_rounds++;
        end else if (ev == EvStart) begin
          m_mode = MClear;
        end else begin
          m_mode = MPaused;
        end
      end
      MPaused: begin
        if (ev == EvStart) m_mode = MClear;
        else if (ev == EvPause) m_mode = MRun;
      end
      MExpired: begin
        if (ev == EvStart) begin
          if (m_rounds == MR) begin
            m_mode   = MIdle;
            m_rounds = 0;
          end else begin
            m_mode = MClear;
          end
        end
      end
      default: ;
    endcase
  endtask

  // Press a key; state should move exactly D+4 edges after the raw edge.
  task automatic press(input int key, input string tag);
    if (key == EvStart) start_key = 1'b0;
    else pause_key = 1'b0;
    tick(D + 3);
    check_all({tag, "_pre"});
    tick(1);
    model_event(key);
    check_all(tag);
    if (m_mode == MClear) begin
      tick(C - 1);
      check_all({tag, "_clr"});
      tick(1);
      m_mode = MRun;
      check_all({tag, "_run"});
    end
    start_key = 1'b1;
    pause_key = 1'b1;
    tick(int'($urandom_range(12, 20)));
    check_all({tag, "_rel"});
  endtask

  // Pulse time_out; a change in RUN should appear exactly 3 edges later.
  task automatic tmo_step(input string tag);
    time_out = 1'b1;
    tick(2);
    check_all({tag, "_pre"});
    tick(1);
    model_event(EvTmo);
    check_all(tag);
    time_out = 1'b0;
    tick(int'($urandom_range(4, 8)));
    check_all({tag, "_rel"});
  endtask

  initial begin
    int g;
    int ev;
    resetn    = 1'b0;
    start_key = 1'b1;
    pause_key = 1'b1;
    time_out  = 1'b0;
    #21;
    check_all("reset");
    resetn = 1'b1;
    tick(12);
    check_all("idle");

    // Short glitch must not start a round.
    g = int'($urandom_range(1, 3));
    start_key = 1'b0;
    tick(g);
    start_key = 1'b1;
    tick(30);
    check_all("glitch");

    press(EvStart, "start1");
    press(EvPause, "pause1");
    tmo_step("tmo_paused");
    press(EvPause, "resume1");
    press(EvPause, "pause2");
    press(EvStart, "restart_paused");
    tmo_step("expire1");
    press(EvPause, "pause_expired");
    press(EvStart, "start2");
    press(EvStart, "restart_run");

    // Pause pulse and synchronized time_out land on the same edge: expiry wins.
    pause_key = 1'b0;
    tick(5);
    time_out = 1'b1;
    tick(2);
    check_all("both_pre");
    tick(1);
    model_event(EvTmo);
    check_all("both");
    pause_key = 1'b1;
    time_out  = 1'b0;
    tick(15);
    check_all("both_rel");

    press(EvStart, "game_over_start");
    press(EvStart, "start3");

    // Asynchronous reset mid-RUN with start held through release.
    start_key = 1'b0;
    #2;
    resetn = 1'b0;
    #2;
    m_mode   = MIdle;
    m_rounds = 0;
    check_all("reset_async");
    tick(2);
    resetn = 1'b1;
    tick(30);
    check_all("reset_held_key");
    start_key = 1'b1;
    tick(15);
    check_all("reset_release_key");
    press(EvStart, "start_after_reset");

    for (int i = 0; i < 16; i++) begin
      ev = int'($urandom_range(0, 2));
      if (ev == EvTmo) tmo_step($sformatf("rnd%0d_tmo", i));
      else press(ev, $sformatf("rnd%0d_key%0d", i, ev));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/round_ctrl.md
# round_ctrl

Game-round sequencer that sits directly upstream of the 30-second countdown timer. It debounces the start and pause pushbuttons and drives the timer's 2-bit control input. It also consumes the timer's `time_out` flag and counts completed rounds until a configurable limit is reached. Because the timer only samples its control bits on its own 1 Hz tick, this block holds clear requests long enough for at least one tick to land.

## Interface
- `DEBOUNCE_CYCLES`, default 1_000_000: number of consecutive stable synchronized samples required to accept a key level (20 ms at 50 MHz).
- `CLEAR_CYCLES`, default 50_000_001: number of cycles the clear request is held. Must exceed one 1 Hz tick period.
- `MAX_ROUNDS`, default 9: number of expired rounds that ends the game (1..15).
- `clock_50` in 1: 50 MHz system clock. All state is updated on its rising edge.
- `resetn` in 1: asynchronous, active-low reset.
- `start_key` in 1: raw pushbutton, active-low (0 = pressed). Asynchronous to the clock.
- `pause_key` in 1: raw pushbutton, active-low. Asynchronous to the clock.
- `time_out` in 1: timer reached 00. Level signal, asynchronous to the clock.
- `timer_ctrl` out 2: control to the timer.
  - bit0 = 1: clear the count to 30 (takes priority).
  - bit1 = 1: hold the count.
  - 00 = count down.
- `round_cnt` out 4: number of expired rounds, 0..MAX_ROUNDS.
- `running` out 1: high in RUN only.
- `game_over` out 1: high when `round_cnt == MAX_ROUNDS`.

## Operation
- **Key path (start and pause, independent copies):**
  - Two-flop synchronizer.
  - Debounce counter that resets on any change of the synchronized level. The stable level is accepted when the counter reaches DEBOUNCE_CYCLES.
  - A press pulse is emitted for exactly one cycle on an accepted 1→0 transition. Release produces no pulse, and holding the key produces a single pulse.
- **`time_out`:** two-flop synchronized to `tmo_s`, used as a level.
- **FSM states and their `timer_ctrl` values:**
  - IDLE: 11
  - CLEAR: 11
  - RUN: 00
  - PAUSED: 10
  - EXPIRED: 10
- **Transitions:**
  - IDLE: start → CLEAR.
  - CLEAR: loads `clr_cnt = CLEAR_CYCLES-1` on entry and decrements each cycle. At `clr_cnt == 0` → RUN. Key pulses are ignored in CLEAR.
  - RUN:
    - `tmo_s` → EXPIRED, and `round_cnt` increments, saturating at MAX_ROUNDS.
    - Otherwise start → CLEAR (restart the round, no count).
    - Otherwise pause → PAUSED.
  - PAUSED: start → CLEAR, else pause → RUN. `tmo_s` is ignored.
  - EXPIRED:
    - If start and not `game_over` → CLEAR.
    - If start and `game_over` → IDLE, and `round_cnt` is cleared to 0.
    - Pause is ignored.
- **Priority within one cycle:** `tmo_s` > start > pause.
- **`round_cnt`** changes only on RUN→EXPIRED (increment) and on EXPIRED→IDLE (clear).
- **Reset (`resetn` low, any state):**
  - State is forced to IDLE.
  - `timer_ctrl` = 11, `round_cnt` = 0, `running` = 0, `game_over` = 0.
  - Debounce and synchronizer flops are forced to the released level (1). No pulse is generated when reset is released while a key is held; that key must be released and pressed again.
- **Widths:** `clr_cnt` and the debounce counters are sized as clog2 of their parameter plus one.

## Timing
- All outputs are registered and decoded from the state register.
- **Key press to `timer_ctrl` change:** 2 (synchronizer) + DEBOUNCE_CYCLES + 1 (pulse) + 1 (state register) cycles after the raw edge.
- **`time_out` rise to `timer_ctrl` = 10:** 3 cycles (2 synchronizer + 1 state). This is far below one 1 Hz tick, so the timer freezes at 00 before its next tick and never wraps.
- **CLEAR duration:** `timer_ctrl` = 11 for exactly CLEAR_CYCLES cycles, then 00 from the next cycle.
- **`running`** rises in the same cycle `timer_ctrl` becomes 00.
- **`game_over`** rises in the same cycle `round_cnt` reaches MAX_ROUNDS.

## Test plan
Test parameters: DEBOUNCE_CYCLES=4, CLEAR_CYCLES=8, MAX_ROUNDS=2.

- **Reset:** reset mid-RUN with `resetn` low → outputs immediately read `timer_ctrl`=11, `round_cnt`=0, `running`=0, `game_over`=0. Holding `start_key`=0 through release of reset produces no transition.
- **Debounce:**
  - `start_key` glitching low for 3 cycles → no pulse, state stays IDLE.
  - A clean press → `timer_ctrl`=11 for 8 cycles, then 00 with `running`=1.
- **Pause:**
  - In RUN, pause press → `timer_ctrl`=10.
  - Second press → 00.
  - Raise `time_out` while PAUSED → no change.
- **Expiry:** in RUN, raise `time_out` → 3 cycles later `timer_ctrl`=10, `round_cnt`=1. Asserting pause and `time_out` in the same cycle still yields EXPIRED.
- **Game over:**
  - Complete a second round → `round_cnt`=2, `game_over`=1.
  - Start → IDLE with `round_cnt`=0 and `game_over`=0.
  - A further start → CLEAR.
- **Restart:** start press in RUN or PAUSED → CLEAR for 8 cycles, then RUN, with `round_cnt` unchanged.
